// File: rtl/sar_pkg.sv
// -----------------------------------------------------------------------------
// sar_pkg
// Shared definitions for the SAR ADC controller:
//   NBIT_DEF    default converter resolution
//   IDX_W       width needed to hold a bit index 0..NBIT_DEF-1
//   sar_state_e controller phases (sample, bit trial, done)
// Optional feature macro used by the design: SAR_COMP_READY_EN (see sar_ctrl).
// -----------------------------------------------------------------------------
package sar_pkg;

  localparam int unsigned NBIT_DEF = 10;
  localparam int unsigned IDX_W    = $clog2(NBIT_DEF);

  typedef enum logic [1:0] {
    ST_SAMPLE = 2'd0,
    ST_TRIAL  = 2'd1,
    ST_DONE   = 2'd2
  } sar_state_e;

endpackage

// File: rtl/sar_bit_reg.sv
// -----------------------------------------------------------------------------
// sar_bit_reg
// Successive-approximation trial register plus one-hot cycle-flag pointer.
// Index 0 is the MSB on every vector.
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   clear_i       zero the trial word and the pointer
//   load_i        start a conversion: trial word = MSB only, pointer at bit 0
//   decide_i      resolve the bit under the pointer with d_i, arm the next bit
//   d_i           comparator decision for the bit under the pointer
//   trial_o       registered trial word (drives the capacitive DAC)
//   trial_next_o  value the trial word takes at the next edge
//   cf_o          registered one-hot pointer (all zero outside the trials)
// -----------------------------------------------------------------------------
module sar_bit_reg
  import sar_pkg::*;
#(
  parameter int unsigned NBIT = NBIT_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            load_i,
  input  logic            decide_i,
  input  logic            d_i,
  output logic [0:NBIT-1] trial_o,
  output logic [0:NBIT-1] trial_next_o,
  output logic [0:NBIT-1] cf_o
);

  logic [0:NBIT-1] trial_q, trial_d;
  logic [0:NBIT-1] cf_q, cf_d;

  // Next trial word and pointer for clear / load / decide / hold.
  always_comb begin
    trial_d = trial_q;
    cf_d    = cf_q;
    if (clear_i) begin
      trial_d = '0;
      cf_d    = '0;
    end else if (load_i) begin
      trial_d    = '0;
      trial_d[0] = 1'b1;
      cf_d       = '0;
      cf_d[0]    = 1'b1;
    end else if (decide_i) begin
      // Pointer moves one bit toward the LSB; the bit it lands on is set to 1
      // as the next trial. Shifting out of the LSB leaves the pointer empty.
      cf_d[0] = 1'b0;
      for (int i = 1; i < int'(NBIT); i++) begin
        cf_d[i] = cf_q[i-1];
        if (cf_q[i-1]) begin
          trial_d[i] = 1'b1;
        end else begin
          trial_d[i] = trial_q[i];
        end
      end
      // The bit currently under trial takes the comparator decision.
      for (int i = 0; i < int'(NBIT); i++) begin
        if (cf_q[i]) begin
          trial_d[i] = d_i;
        end else begin
          trial_d[i] = trial_d[i];
        end
      end
    end else begin
      trial_d = trial_q;
      cf_d    = cf_q;
    end
  end

  // Trial word and pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trial_q <= '0;
      cf_q    <= '0;
    end else begin
      trial_q <= trial_d;
      cf_q    <= cf_d;
    end
  end

  assign trial_o      = trial_q;
  assign trial_next_o = trial_d;
  assign cf_o         = cf_q;

endmodule

// File: rtl/sar_ctrl.sv
// -----------------------------------------------------------------------------
// sar_ctrl
// Controller for a fully-differential charge-redistribution SAR ADC.
// Sequence: SAMPLE (SAMPLE_CYCLES cycles) -> one TRIAL per bit -> DONE, repeated
// while ENABLE is high. ENABLE low is an asynchronous reset of all state.
// Ports:
//   CLK            system clock (rising edge)
//   ENABLE         asynchronous active-low reset / run enable
//   COMP_P/COMP_N  comparator outputs (COMP_P=1 keeps the trial bit)
//   CLKS/CLKSB     sample switch control and its inverse
//   EOC            one-cycle end-of-conversion strobe
//   CF             one-hot flag of the bit under trial
//   DOUT           last completed result (index 0 = MSB)
//   CDAC_P/CDAC_N  P-side DAC word (trial register) and its complement
// Optional feature macro: SAR_COMP_READY_EN -- when defined a trial only
// advances on an edge with COMP_P ^ COMP_N = 1; otherwise it stalls.
// All outputs come from registers; comparator inputs only reach next-state
// logic.
// -----------------------------------------------------------------------------
module sar_ctrl
  import sar_pkg::*;
#(
  parameter int unsigned NBIT          = NBIT_DEF,
  parameter int unsigned SAMPLE_CYCLES = 1
) (
  input  logic            CLK,
  input  logic            ENABLE,
  input  logic            COMP_P,
  input  logic            COMP_N,
  output logic            CLKS,
  output logic            CLKSB,
  output logic            EOC,
  output logic [0:NBIT-1] CF,
  output logic [0:NBIT-1] DOUT,
  output logic [0:NBIT-1] CDAC_P,
  output logic [0:NBIT-1] CDAC_N
);

  localparam int unsigned     CNT_W    = $clog2(SAMPLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CYCLES);

  sar_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clks_q, clks_d;
  logic             eoc_q, eoc_d;
  logic [0:NBIT-1]  dout_q, dout_d;

  logic             clear_s, load_s, decide_s, valid_s;
  logic [0:NBIT-1]  trial_s, trial_next_s, cf_s;

`ifdef SAR_COMP_READY_EN
  // Only a complementary comparator pair is a resolved decision.
  assign valid_s = COMP_P ^ COMP_N;
`else
  logic unused_comp_n_s;
  assign valid_s         = 1'b1;
  assign unused_comp_n_s = COMP_N;
`endif

  // Phase sequencing, sample counter and next values of the output registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clks_d   = 1'b0;
    eoc_d    = 1'b0;
    dout_d   = dout_q;
    clear_s  = 1'b0;
    load_s   = 1'b0;
    decide_s = 1'b0;
    case (state_q)
      ST_SAMPLE: begin
        // The counter starts at 0 out of reset (reset-hold cycle shows CLKS=0)
        // and at 1 out of DONE, so CLKS is high for SAMPLE_CYCLES cycles.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_TRIAL;
          cnt_d   = '0;
          load_s  = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          clks_d  = 1'b1;
          clear_s = 1'b1;
        end
      end
      ST_TRIAL: begin
        if (valid_s) begin
          decide_s = 1'b1;
          if (cf_s[NBIT-1]) begin
            state_d = ST_DONE;
            eoc_d   = 1'b1;
            dout_d  = trial_next_s;
          end else begin
            state_d = ST_TRIAL;
          end
        end else begin
          state_d = ST_TRIAL;
        end
      end
      ST_DONE: begin
        state_d = ST_SAMPLE;
        cnt_d   = CNT_W'(1);
        clks_d  = 1'b1;
        clear_s = 1'b1;
      end
      default: begin
        state_d = ST_SAMPLE;
        cnt_d   = '0;
        clear_s = 1'b1;
      end
    endcase
  end

  // FSM state, sample counter and output registers.
  always_ff @(posedge CLK or negedge ENABLE) begin
    if (!ENABLE) begin
      state_q <= ST_SAMPLE;
      cnt_q   <= '0;
      clks_q  <= 1'b0;
      eoc_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clks_q  <= clks_d;
      eoc_q   <= eoc_d;
      dout_q  <= dout_d;
    end
  end

  sar_bit_reg #(
    .NBIT (NBIT)
  ) u_bit_reg (
    .clk_i        (CLK),
    .rst_ni       (ENABLE),
    .clear_i      (clear_s),
    .load_i       (load_s),
    .decide_i     (decide_s),
    .d_i          (COMP_P),
    .trial_o      (trial_s),
    .trial_next_o (trial_next_s),
    .cf_o         (cf_s)
  );

  assign CLKS   = clks_q;
  assign CLKSB  = ~clks_q;
  assign EOC    = eoc_q;
  assign CF     = cf_s;
  assign DOUT   = dout_q;
  assign CDAC_P = trial_s;
  assign CDAC_N = ~trial_s;

endmodule

// File: tb/tb_sar_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sar_ctrl
// Self-checking bench for sar_ctrl (NBIT=10, SAMPLE_CYCLES=1). The reference is
// an ideal binary search: for an analog input code vin, each trial compares
// vin against the prefix-plus-trial-bit DAC value, so the expected DAC words,
// cycle flags, EOC timing and final code all follow from integer arithmetic.
// -----------------------------------------------------------------------------
module tb_sar_ctrl;

  localparam int NB = 10;

  logic          CLK = 1'b0;
  logic          ENABLE;
  logic          COMP_P;
  logic          COMP_N;
  logic          CLKS;
  logic          CLKSB;
  logic          EOC;
  logic [0:NB-1] CF;
  logic [0:NB-1] DOUT;
  logic [0:NB-1] CDAC_P;
  logic [0:NB-1] CDAC_N;

  int checks   = 0;
  int errors   = 0;
  int edges    = 0;
  int last_eoc = 0;
  int prev_out = 0;

  sar_ctrl #(
    .NBIT          (NB),
    .SAMPLE_CYCLES (1)
  ) dut (
    .CLK    (CLK),
    .ENABLE (ENABLE),
    .COMP_P (COMP_P),
    .COMP_N (COMP_N),
    .CLKS   (CLKS),
    .CLKSB  (CLKSB),
    .EOC    (EOC),
    .CF     (CF),
    .DOUT   (DOUT),
    .CDAC_P (CDAC_P),
    .CDAC_N (CDAC_N)
  );

  always #5 CLK = ~CLK;

  // Rising edges since ENABLE was last released (edge 1 = first edge high).
  always @(posedge CLK or negedge ENABLE) begin
    if (!ENABLE) edges <= 0;
    else         edges <= edges + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_clks"},   CLKS,   0);
    chk({tag, "_clksb"},  CLKSB,  1);
    chk({tag, "_eoc"},    EOC,    0);
    chk({tag, "_cf"},     CF,     0);
    chk({tag, "_dout"},   DOUT,   0);
    chk({tag, "_cdac_p"}, CDAC_P, 0);
    chk({tag, "_cdac_n"}, CDAC_N, 32'h3FF);
  endtask

  // One full conversion of analog code vin, starting from the edge that enters
  // the sample phase. tie_n drives COMP_N equal to COMP_P; stall0 inserts that
  // many 0/0 comparator cycles in trial 0; abort_at drops ENABLE in that trial.
  task automatic convert(input int vin, input bit tie_n, input int stall0, input int abort_at);
    int  prefix;
    int  dac;
    bit  comp;
    prefix = 0;
    @(posedge CLK); @(negedge CLK);
    chk("smp_clks",   CLKS,   1);
    chk("smp_clksb",  CLKSB,  0);
    chk("smp_eoc",    EOC,    0);
    chk("smp_cf",     CF,     0);
    chk("smp_cdac_p", CDAC_P, 0);
    chk("smp_dout",   DOUT,   prev_out);
    for (int k = 0; k < NB; k++) begin
      @(posedge CLK); @(negedge CLK);
      dac = prefix | (1 << (NB - 1 - k));
      chk("trl_cf",     CF,     1 << (NB - 1 - k));
      chk("trl_cdac_p", CDAC_P, dac);
      chk("trl_cdac_n", CDAC_N, (~dac) & 32'h3FF);
      chk("trl_clks",   CLKS,   0);
      chk("trl_eoc",    EOC,    0);
      chk("trl_dout",   DOUT,   prev_out);
      if (k == abort_at) begin
        #2 ENABLE = 1'b0;
        #1 chk_reset_vals("abort");
        return;
      end
      if (k == 0) begin
        for (int s = 0; s < stall0; s++) begin
          COMP_P = 1'b0;
          COMP_N = 1'b0;
          @(posedge CLK); @(negedge CLK);
          chk("stall_cf",   CF,     1 << (NB - 1));
          chk("stall_cdac", CDAC_P, dac);
          chk("stall_eoc",  EOC,    0);
        end
      end
      comp   = (vin >= dac);
      COMP_P = comp;
      COMP_N = tie_n ? comp : !comp;
      if (comp) prefix = dac;
    end
    @(posedge CLK); @(negedge CLK);
    chk("done_eoc",    EOC,    1);
    chk("done_dout",   DOUT,   vin);
    chk("done_cf",     CF,     0);
    chk("done_clks",   CLKS,   0);
    chk("done_clksb",  CLKSB,  1);
    chk("done_cdac_p", CDAC_P, vin);
    chk("done_period", edges - last_eoc, 12 + stall0);
    last_eoc = edges;
    prev_out = vin;
    COMP_P   = 1'b0;
    COMP_N   = 1'b1;
  endtask

  initial begin
    ENABLE = 1'b0;
    COMP_P = 1'b0;
    COMP_N = 1'b1;
    #12 chk_reset_vals("reset");
    @(negedge CLK) ENABLE = 1'b1;

    // Constant keep, constant clear, then two alternating back-to-back.
    convert(1023, 1'b0, 0, -1);
    convert(0,    1'b0, 0, -1);
    convert(682,  1'b0, 0, -1);
    convert(682,  1'b0, 0, -1);
    for (int r = 0; r < 4; r++) begin
      convert(int'($urandom_range(0, 1023)), 1'b0, 0, -1);
    end

    // Abort in trial 5, stay in reset for a while, then restart cleanly.
    convert(int'($urandom_range(1, 1023)), 1'b0, 0, 5);
    repeat (2) @(negedge CLK);
    chk_reset_vals("held");
    last_eoc = 0;
    prev_out = 0;
    ENABLE   = 1'b1;
    convert(341, 1'b0, 0, -1);

`ifdef SAR_COMP_READY_EN
    // Invalid 0/0 decisions freeze trial 0; EOC moves out by the stall count.
    convert(896, 1'b0, 3, -1);
`else
    // 0/0 decisions are taken as COMP_P=0 with no stall.
    convert(0, 1'b1, 0, -1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
